// File: rtl/insn_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, fault codes,
// the NOP encoding and the target alignment helper.
package insn_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  CAUSE_NONE     = 2'b00;
  localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // No compressed ISA: any set bit in [1:0] makes a target unusable.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/insn_fetch_unit_timeout_counter.sv
// Counts consecutive request cycles without an acknowledge and flags the cycle
// in which the TIMEOUT-th such cycle is being spent.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_r;

  // Waiting-cycle counter; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Fires while the last permitted un-acked cycle is in progress.
  always_comb begin
    expired = 1'b0;
    if (enable && (count_r == CW'(TIMEOUT - 1))) begin
      expired = 1'b1;
    end else begin
      expired = 1'b0;
    end
  end

endmodule

// File: rtl/insn_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake, holds the word
// for decode/execute, advances the PC and halts on misaligned target or timeout.
module insn_fetch_unit
  import insn_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     insn,
  output logic [XLEN-1:0] pc,
  output logic            insn_valid,
  input  logic            exec_done,
  input  logic            pc_next_sel,
  input  logic [XLEN-1:0] pc_target,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  fetch_state_e    state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s, pc_cand_s;
  logic [31:0]     insn_r, insn_nxt_s;
  logic [1:0]      cause_r, cause_nxt_s;
  logic            imem_req_r, insn_valid_r, fault_r;
  logic            tmo_clear_s, tmo_en_s, tmo_expired_s;

  // Timeout counter runs only while waiting in REQ; an ack restarts it.
  always_comb begin
    tmo_en_s    = 1'b0;
    tmo_clear_s = 1'b1;
    if (state_r == ST_REQ) begin
      tmo_en_s    = ~imem_ack;
      tmo_clear_s = imem_ack;
    end else begin
      tmo_en_s    = 1'b0;
      tmo_clear_s = 1'b1;
    end
  end

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear_s),
    .enable  (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Next-state, next-PC and fault-cause selection.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    insn_nxt_s  = insn_r;
    cause_nxt_s = cause_r;
    // pc+4 wraps modulo 2^XLEN by construction of the adder width
    pc_cand_s   = pc_next_sel ? pc_target : (pc_r + XLEN'(4));
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          insn_nxt_s  = imem_rdata;
          state_nxt_s = ST_ISSUE;
        end else if (tmo_expired_s) begin
          state_nxt_s = ST_HALT;
          cause_nxt_s = CAUSE_TIMEOUT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_ISSUE: begin
        if (exec_done) begin
          if (pc_next_sel && is_misaligned(pc_target[1:0])) begin
            state_nxt_s = ST_HALT;
            cause_nxt_s = CAUSE_MISALIGN;
          end else begin
            pc_nxt_s    = pc_cand_s;
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
  end

  // State, PC, instruction and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      insn_r       <= NOP_INSN;
      cause_r      <= CAUSE_NONE;
      imem_req_r   <= 1'b0;
      insn_valid_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      insn_r       <= insn_nxt_s;
      cause_r      <= cause_nxt_s;
      imem_req_r   <= (state_nxt_s == ST_REQ);
      insn_valid_r <= (state_nxt_s == ST_ISSUE);
      fault_r      <= (state_nxt_s == ST_HALT);
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign insn        = insn_r;
  assign pc          = pc_r;
  assign insn_valid  = insn_valid_r;
  assign fault       = fault_r;
  assign fault_cause = cause_r;

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed plus randomized bench for insn_fetch_unit; expectations come from a
// transaction-level model of PC, instruction word and fault status.
module tb_insn_fetch_unit;

  localparam int          TMO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] insn;
  logic [63:0] pc;
  logic        insn_valid;
  logic        exec_done = 1'b0;
  logic        pc_next_sel = 1'b0;
  logic [63:0] pc_target = 64'h0;
  logic        fault;
  logic [1:0]  fault_cause;

  int          total = 0;
  int          bad = 0;
  logic [63:0] model_pc;
  logic [31:0] model_insn;

  insn_fetch_unit #(
    .XLEN     (64),
    .RESET_PC (64'h0),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .insn        (insn),
    .pc          (pc),
    .insn_valid  (insn_valid),
    .exec_done   (exec_done),
    .pc_next_sel (pc_next_sel),
    .pc_target   (pc_target),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    #2;
    model_pc = 64'h0; model_insn = NOP;
    chk("rst_req",   64'(imem_req), 64'd0);
    chk("rst_valid", 64'(insn_valid), 64'd0);
    chk("rst_insn",  64'(insn), 64'(NOP));
    chk("rst_pc",    pc, 64'h0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_cause", 64'(fault_cause), 64'd0);
    step();
    rst_n = 1'b1;
    chk("boot_req", 64'(imem_req), 64'd0);
    step();
    chk("req_after_boot", 64'(imem_req), 64'd1);
  endtask

  // Waits `delay` un-acked REQ cycles, then acks with `data`.
  task automatic fetch(input int delay, input logic [31:0] data);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      exec_done = 1'($urandom); pc_next_sel = 1'($urandom);
      chk("wait_req",   64'(imem_req), 64'd1);
      chk("wait_valid", 64'(insn_valid), 64'd0);
      chk("wait_addr",  imem_addr, model_pc);
      step();
    end
    imem_ack = 1'b1; imem_rdata = data; exec_done = 1'($urandom);
    chk("ack_req",  64'(imem_req), 64'd1);
    chk("ack_addr", imem_addr, model_pc);
    step();
    imem_ack = 1'b0; exec_done = 1'b0;
    model_insn = data;
    chk("issue_valid", 64'(insn_valid), 64'd1);
    chk("issue_req",   64'(imem_req), 64'd0);
    chk("issue_insn",  64'(insn), 64'(model_insn));
    chk("issue_pc",    pc, model_pc);
  endtask

  // Stray acks while in ISSUE must not disturb the held instruction.
  task automatic issue_idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      step();
      chk("idle_valid", 64'(insn_valid), 64'd1);
      chk("idle_insn",  64'(insn), 64'(model_insn));
    end
    imem_ack = 1'b0;
  endtask

  task automatic execute(input logic sel, input logic [63:0] target);
    exec_done = 1'b1; pc_next_sel = sel; pc_target = target;
    step();
    exec_done = 1'b0;
    if (sel && (target[1:0] != 2'b00)) begin
      chk("mis_fault", 64'(fault), 64'd1);
      chk("mis_cause", 64'(fault_cause), 64'd1);
      chk("mis_pc",    pc, model_pc);
      chk("mis_req",   64'(imem_req), 64'd0);
    end else begin
      model_pc = sel ? target : model_pc + 64'd4;
      chk("next_req",   64'(imem_req), 64'd1);
      chk("next_addr",  imem_addr, model_pc);
      chk("next_valid", 64'(insn_valid), 64'd0);
      chk("next_fault", 64'(fault), 64'd0);
    end
  endtask

  task automatic check_halt(input logic [1:0] cause, input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom); exec_done = 1'($urandom);
      pc_next_sel = 1'($urandom); pc_target = {$urandom, $urandom};
      step();
      chk("halt_fault", 64'(fault), 64'd1);
      chk("halt_cause", 64'(fault_cause), 64'(cause));
      chk("halt_req",   64'(imem_req), 64'd0);
      chk("halt_valid", 64'(insn_valid), 64'd0);
      chk("halt_pc",    pc, model_pc);
    end
    imem_ack = 1'b0; exec_done = 1'b0;
  endtask

  initial begin
    logic [63:0] tgt;
    step();
    // first fetch, ack on the second REQ cycle
    do_reset();
    fetch(1, 32'h0050_0093);
    // sequential and taken paths from 0x100; ack on the last allowed cycle
    execute(1'b1, 64'h100);
    fetch(0, $urandom);
    issue_idle(2);
    execute(1'b0, 64'hDEAD_0000);
    fetch(2, $urandom);
    execute(1'b1, 64'h100);
    fetch(0, $urandom);
    execute(1'b1, 64'h2000);
    fetch(TMO - 1, $urandom);
    fetch_again: begin
      execute(1'b0, 64'h0);
      fetch(TMO - 1, $urandom);
    end
    execute(1'b1, 64'h100);
    fetch(0, $urandom);
    // misaligned branch target
    execute(1'b1, 64'h2002);
    check_halt(2'b01, 4);
    // pc+4 wraps to zero without a fault
    do_reset();
    fetch(0, $urandom);
    execute(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(1, $urandom);
    execute(1'b0, 64'h0);
    chk("wrap_pc", pc, 64'h0);
    fetch(2, $urandom);
    // memory never answers
    do_reset();
    for (int i = 0; i < TMO; i++) begin
      imem_ack = 1'b0;
      chk("tmo_req",   64'(imem_req), 64'd1);
      chk("tmo_fault", 64'(fault), 64'd0);
      step();
    end
    chk("tmo_fault_set", 64'(fault), 64'd1);
    chk("tmo_cause",     64'(fault_cause), 64'd2);
    check_halt(2'b10, 3);
    // randomized fetch/execute traffic
    do_reset();
    for (int n = 0; n < 40; n++) begin
      fetch($urandom_range(0, TMO - 1), $urandom);
      issue_idle($urandom_range(0, 2));
      tgt = {$urandom, $urandom};
      tgt[1:0] = 2'b00;
      execute(1'($urandom), tgt);
    end
    // reset in the middle of a request, stale ack during BOOT
    fetch(1, $urandom);
    execute(1'b0, 64'h0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    model_pc = 64'h0; model_insn = NOP;
    step();
    imem_ack = 1'b0;
    chk("boot_ack_insn",  64'(insn), 64'(NOP));
    chk("boot_ack_valid", 64'(insn_valid), 64'd0);
    chk("boot_ack_req",   64'(imem_req), 64'd1);
    chk("boot_ack_pc",    pc, 64'h0);
    fetch(0, 32'h0010_0113);
    // random misaligned target ends in HALT
    tgt = {$urandom, $urandom};
    tgt[1:0] = 2'($urandom_range(1, 3));
    execute(1'b1, tgt);
    check_halt(2'b01, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
